// File: rtl/ca_pkg.sv
// Shared constants and entry types for the instruction-cache array.
package ca_pkg;

  localparam int unsigned CA_CACHE_ENTRIES = 8;
  localparam int unsigned PC_WIDTH         = 32;
  localparam int unsigned INSTR_WIDTH      = 32;
  localparam int unsigned STAT_WIDTH       = 16;

  typedef logic [PC_WIDTH-1:2] ca_tag_t;

  typedef struct packed {
    logic                   valid;
    ca_tag_t                tag;
    logic [INSTR_WIDTH-1:0] data;
  } ca_entry_t;

endpackage

// File: rtl/ca_first_free.sv
// Priority encoder: lowest index whose valid bit is clear.
module ca_first_free #(
  parameter int unsigned N  = 8,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  output logic [IW-1:0] free_idx,
  output logic          any_free
);

  // Scan from the top so the lowest free index is the last one written.
  always_comb begin
    free_idx = '0;
    any_free = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        free_idx = IW'(i);
        any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ca_array.sv
// Fully associative instruction-cache storage with combinational lookup,
// self-allocating fills and saturating hit/miss statistics.
module ca_array
  import ca_pkg::*;
#(
  parameter int unsigned CACHE_ENTRIES   = CA_CACHE_ENTRIES,
  parameter int unsigned CACHE_ADDR_LEFT = $clog2(CACHE_ENTRIES) - 1
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic [PC_WIDTH-1:0]    pc,
  input  logic                   cache_read,
  input  logic                   cache_write_,
  input  logic [CACHE_ADDR_LEFT:0] cache_w_addr,
  input  logic                   new_valid,
  input  logic [INSTR_WIDTH-1:0] mem_instr,
  output logic                   cache_hit,
  output logic                   cache_full,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [STAT_WIDTH-1:0]  hit_count,
  output logic [STAT_WIDTH-1:0]  miss_count
);

  localparam int unsigned IW = CACHE_ADDR_LEFT + 1;

  ca_entry_t          entry_q [CACHE_ENTRIES];
  logic [CACHE_ENTRIES-1:0] valid_vec;
  ca_tag_t            pc_tag;
  logic               pc_lsb_unused;
  logic               match_any;
  logic [IW-1:0]      match_idx;
  logic [IW-1:0]      free_idx;
  logic               any_free;
  logic [IW-1:0]      fill_idx;

  assign pc_tag        = pc[PC_WIDTH-1:2];
  assign pc_lsb_unused = ^pc[1:0];

  always_comb begin
    valid_vec = '0;
    for (int i = 0; i < CACHE_ENTRIES; i++) valid_vec[i] = entry_q[i].valid;
  end

  // Tag match, lowest matching index wins (at most one by construction).
  always_comb begin
    match_any = 1'b0;
    match_idx = '0;
    for (int i = CACHE_ENTRIES - 1; i >= 0; i--) begin
      if (entry_q[i].valid && (entry_q[i].tag == pc_tag)) begin
        match_any = 1'b1;
        match_idx = IW'(i);
      end
    end
  end

  ca_first_free #(.N(CACHE_ENTRIES), .IW(IW)) u_first_free (
    .valid    (valid_vec),
    .free_idx (free_idx),
    .any_free (any_free)
  );

  assign cache_hit  = cache_read & cache_write_ & match_any;
  assign instr      = cache_hit ? entry_q[match_idx].data : '0;
  assign cache_full = &valid_vec;

  // Refill of an already-cached tag reuses its slot so tags stay unique.
  always_comb begin
    if (match_any)     fill_idx = match_idx;
    else if (any_free) fill_idx = free_idx;
    else               fill_idx = cache_w_addr;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int i = 0; i < CACHE_ENTRIES; i++) entry_q[i] <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (!cache_write_) begin
        if (new_valid) begin
          entry_q[fill_idx].valid <= 1'b1;
          entry_q[fill_idx].tag   <= pc_tag;
          entry_q[fill_idx].data  <= mem_instr;
        end else begin
          entry_q[cache_w_addr].valid <= 1'b0;
        end
      end
      if (cache_read && cache_write_) begin
        if (cache_hit) begin
          if (hit_count != '1) hit_count <= hit_count + STAT_WIDTH'(1);
        end else begin
          if (miss_count != '1) miss_count <= miss_count + STAT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ca_array.sv
// Self-checking bench for ca_array: directed plan plus randomized traffic
// against an associative reference model.
module tb_ca_array;

  logic        clk = 1'b0;
  logic        rst_ = 1'b0;
  logic [31:0] pc = '0;
  logic        cache_read = 1'b0;
  logic        cache_write_ = 1'b1;
  logic [2:0]  cache_w_addr = '0;
  logic        new_valid = 1'b0;
  logic [31:0] mem_instr = '0;
  logic        cache_hit;
  logic        cache_full;
  logic [31:0] instr;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int total = 0;
  int bad   = 0;

  // Reference model: slot contents and statistics.
  logic        mv [8];
  logic [29:0] mt [8];
  logic [31:0] md [8];
  int          mh;
  int          mm;

  ca_array dut (
    .clk          (clk),
    .rst_         (rst_),
    .pc           (pc),
    .cache_read   (cache_read),
    .cache_write_ (cache_write_),
    .cache_w_addr (cache_w_addr),
    .new_valid    (new_valid),
    .mem_instr    (mem_instr),
    .cache_hit    (cache_hit),
    .cache_full   (cache_full),
    .instr        (instr),
    .hit_count    (hit_count),
    .miss_count   (miss_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 8; i++) begin
      mv[i] = 1'b0; mt[i] = '0; md[i] = '0;
    end
    mh = 0; mm = 0;
  endfunction

  function automatic int m_find(input logic [31:0] p);
    for (int i = 0; i < 8; i++)
      if (mv[i] && mt[i] == p[31:2]) return i;
    return -1;
  endfunction

  function automatic logic m_full();
    for (int i = 0; i < 8; i++) if (!mv[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void m_clock(input logic rd, input logic wr_n, input logic [2:0] wa,
                                  input logic nv, input logic [31:0] p, input logic [31:0] mi);
    int k;
    k = m_find(p);
    if (rd && wr_n) begin
      if (k >= 0) mh = (mh < 65535) ? mh + 1 : mh;
      else        mm = (mm < 65535) ? mm + 1 : mm;
    end
    if (!wr_n) begin
      if (!nv) mv[wa] = 1'b0;
      else begin
        if (k < 0) begin
          for (int i = 7; i >= 0; i--) if (!mv[i]) k = i;
          if (k < 0) k = int'(wa);
        end
        mv[k] = 1'b1; mt[k] = p[31:2]; md[k] = mi;
      end
    end
  endfunction

  // One controller cycle: drive at negedge, check lookup, clock, check counters.
  task automatic step(input logic rd, input logic wr_n, input logic [2:0] wa,
                      input logic nv, input logic [31:0] p, input logic [31:0] mi);
    int k;
    logic        eh;
    logic [31:0] ed;
    cache_read = rd; cache_write_ = wr_n; cache_w_addr = wa;
    new_valid = nv; pc = p; mem_instr = mi;
    #1;
    k  = m_find(p);
    eh = rd && wr_n && (k >= 0);
    ed = eh ? md[k] : 32'h0;
    check("cache_hit", 32'(cache_hit), 32'(eh));
    check("instr", instr, ed);
    check("cache_full", 32'(cache_full), 32'(m_full()));
    @(posedge clk);
    m_clock(rd, wr_n, wa, nv, p, mi);
    @(negedge clk);
    check("hit_count", 32'(hit_count), 32'(mh));
    check("miss_count", 32'(miss_count), 32'(mm));
  endtask

  task automatic fill(input logic [31:0] p, input logic [31:0] mi);
    step(1'b0, 1'b0, 3'd0, 1'b1, p, mi);
  endtask

  task automatic look(input logic [31:0] p);
    step(1'b1, 1'b1, 3'd0, 1'b0, p, 32'h0);
  endtask

  task automatic do_reset();
    cache_read = 1'b0; cache_write_ = 1'b1;
    rst_ = 1'b0;
    m_reset();
    @(negedge clk);
    rst_ = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int n;
    logic [31:0] p;
    m_reset();
    repeat (2) @(negedge clk);
    rst_ = 1'b1;
    @(negedge clk);

    // 1: empty cache misses
    check("reset_full", 32'(cache_full), 32'h0);
    check("reset_hit_count", 32'(hit_count), 32'h0);
    look(32'h0040_0000);
    check("t1_miss_count", 32'(miss_count), 32'd1);

    // 2: single fill hits
    fill(32'h0040_0004, 32'h2008_0005);
    look(32'h0040_0004);
    look(32'h0040_0007);

    // 3: eight fills allocate slots 0..7
    do_reset();
    for (int i = 0; i < 8; i++) fill(32'h0040_0000 + 32'(4 * i), 32'h1000_0000 + 32'(i));
    check("t3_full", 32'(cache_full), 32'h1);
    for (int i = 0; i < 8; i++) look(32'h0040_0000 + 32'(4 * i));

    // 4: clear slot 3, refill lands there
    step(1'b0, 1'b0, 3'd3, 1'b0, 32'h0, 32'h0);
    check("t4_not_full", 32'(cache_full), 32'h0);
    look(32'h0040_000C);
    fill(32'h0040_0100, 32'hCAFE_0100);
    check("t4_full_again", 32'(cache_full), 32'h1);
    look(32'h0040_0100);
    step(1'b0, 1'b0, 3'd3, 1'b0, 32'h0, 32'h0);
    look(32'h0040_0100);

    // 5: duplicate fill overwrites in place
    fill(32'h0040_0004, 32'hDEAD_BEEF);
    look(32'h0040_0004);
    check("t5_full", 32'(cache_full), 32'h0);
    step(1'b0, 1'b0, 3'd1, 1'b0, 32'h0, 32'h0);
    look(32'h0040_0004);

    // 6: hit counter saturation
    fill(32'h0040_0010, 32'h0000_0010);
    n = 16'hFFFE - mh;
    cache_read = 1'b1; cache_write_ = 1'b1; pc = 32'h0040_0010;
    repeat (n) @(posedge clk);
    @(negedge clk);
    mh = 16'hFFFE;
    check("t6_preload", 32'(hit_count), 32'h0000_FFFE);
    for (int i = 0; i < 3; i++) look(32'h0040_0010);
    check("t6_saturated", 32'(hit_count), 32'h0000_FFFF);

    // 6: asynchronous reset in the middle of a fill
    cache_read = 1'b0; cache_write_ = 1'b0; new_valid = 1'b1;
    cache_w_addr = 3'd0; pc = 32'h0040_0200; mem_instr = 32'h1234_5678;
    #2 rst_ = 1'b0;
    m_reset();
    #1;
    check("t6_rst_full", 32'(cache_full), 32'h0);
    check("t6_rst_hits", 32'(hit_count), 32'h0);
    @(posedge clk);
    @(negedge clk);
    cache_write_ = 1'b1;
    rst_ = 1'b1;
    @(negedge clk);
    look(32'h0040_0200);
    look(32'h0040_0010);

    // Randomized controller traffic over a tag pool larger than the cache
    for (int i = 0; i < 500; i++) begin
      p = 32'h0040_0000 + 32'(4 * $urandom_range(0, 11)) + 32'($urandom_range(0, 3));
      n = $urandom_range(0, 99);
      if (n < 60)      look(p);
      else if (n < 85) step(1'b0, 1'b0, 3'($urandom_range(0, 7)), 1'b1, p, $urandom);
      else             step(1'b0, 1'b0, 3'($urandom_range(0, 7)), 1'b0, p, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
